// File: rtl/pifo_core.sv
// Push-in/first-out priority queue: sorted entry array, two push ports, one port-filtered pop.
// Define PIFO_DROP_EN to include evict-on-push, evict-on-full and the eviction report path.
module pifo_core #(
    parameter int NUMPIFO = 1024,
    parameter int BITPORT = 1,
    parameter int BITPRIO = 16,
    parameter int BITDATA = 10,
    parameter int PIFO_ID = 0
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               pop_0,
    input  logic [BITPORT-1:0] oprt_0,
    output logic               ovld_0,
    output logic [BITPRIO-1:0] opri_0,
    output logic [BITDATA-1:0] odout_0,

    input  logic               push_1,
    input  logic [BITPORT-1:0] uprt_1,
    input  logic [BITPRIO-1:0] upri_1,
    input  logic [BITDATA-1:0] udin_1,
    input  logic               push_1_drop,

    input  logic               push_2,
    input  logic [BITPORT-1:0] uprt_2,
    input  logic [BITPRIO-1:0] upri_2,
    input  logic [BITDATA-1:0] udin_2,
    input  logic               push_2_drop,

    output logic               odrop_vld_0,
    output logic [BITPRIO-1:0] odrop_pri_0,
    output logic [BITDATA-1:0] odrop_dout_0
);

    localparam int CW = $clog2(NUMPIFO + 2);
    localparam int IW = $clog2(NUMPIFO + 1);
    localparam int unused_pifo_id = PIFO_ID;

    typedef struct packed {
        logic [BITPORT-1:0] prt;
        logic [BITPRIO-1:0] pri;
        logic [BITDATA-1:0] dat;
    } entry_t;

    // One spare slot so an insert into a full array can precede the eviction.
    typedef entry_t [NUMPIFO:0] arr_t;

    arr_t           mem_q;
    logic [CW-1:0]  cnt_q;

    arr_t           s;
    int unsigned    c;
    logic           pop_hit;
    int unsigned    pop_idx;
    logic [BITPRIO-1:0] pop_pri;
    logic [BITDATA-1:0] pop_dat;
    entry_t         e1;
    entry_t         e2;

    // Ties keep arrival order: the new entry lands after every entry with prio <= its own.
    function automatic arr_t ins(input arr_t a, input int unsigned n, input entry_t e);
        arr_t        r;
        int unsigned pos;
        pos = 0;
        for (int unsigned i = 0; i <= NUMPIFO; i++) begin
            if (i < n && a[i].pri <= e.pri) pos++;
        end
        for (int unsigned i = 0; i <= NUMPIFO; i++) begin
            if (i < pos)       r[i] = a[i];
            else if (i == pos) r[i] = e;
            else               r[i] = a[IW'(i - 1)];
        end
        return r;
    endfunction

`ifdef PIFO_DROP_EN
    typedef struct packed {
        logic [BITPRIO-1:0] pri;
        logic [BITDATA-1:0] dat;
    } rep_t;

    logic ev1_vld;
    logic ev2_vld;
    rep_t ev1;
    rep_t ev2;
`else
    logic unused_drop;
    assign unused_drop = push_1_drop ^ push_2_drop;
`endif

    always_comb begin
        s       = mem_q;
        c       = 32'(cnt_q);
        pop_hit = 1'b0;
        pop_idx = 0;
        e1.prt  = uprt_1;
        e1.pri  = upri_1;
        e1.dat  = udin_1;
        e2.prt  = uprt_2;
        e2.pri  = upri_2;
        e2.dat  = udin_2;
`ifdef PIFO_DROP_EN
        ev1_vld = 1'b0;
        ev2_vld = 1'b0;
        ev1     = '0;
        ev2     = '0;
`endif

        // Pop sees only entries stored before this cycle.
        if (pop_0) begin
            for (int unsigned i = 0; i < NUMPIFO; i++) begin
                if (!pop_hit && i < c && mem_q[i].prt == oprt_0) begin
                    pop_hit = 1'b1;
                    pop_idx = i;
                end
            end
        end
        pop_pri = mem_q[IW'(pop_idx)].pri;
        pop_dat = mem_q[IW'(pop_idx)].dat;
        if (pop_hit) begin
            for (int unsigned i = 0; i < NUMPIFO; i++) begin
                if (i >= pop_idx) s[i] = s[IW'(i + 1)];
            end
            c = c - 1;
        end

`ifdef PIFO_DROP_EN
        // Each drop push inserts first, then evicts the tail (largest prio, newest among ties).
        if (push_1) begin
            s = ins(s, c, e1);
            c = c + 1;
            if (push_1_drop || c > NUMPIFO) begin
                ev1_vld = 1'b1;
                ev1.pri = s[IW'(c - 1)].pri;
                ev1.dat = s[IW'(c - 1)].dat;
                c       = c - 1;
            end
        end
        if (push_2) begin
            s = ins(s, c, e2);
            c = c + 1;
            if (push_2_drop || c > NUMPIFO) begin
                ev2_vld = 1'b1;
                ev2.pri = s[IW'(c - 1)].pri;
                ev2.dat = s[IW'(c - 1)].dat;
                c       = c - 1;
            end
        end
`else
        if (push_1 && c < NUMPIFO) begin
            s = ins(s, c, e1);
            c = c + 1;
        end
        if (push_2 && c < NUMPIFO) begin
            s = ins(s, c, e2);
            c = c + 1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            cnt_q   <= '0;
            ovld_0  <= 1'b0;
            opri_0  <= '0;
            odout_0 <= '0;
        end else begin
            mem_q  <= s;
            cnt_q  <= CW'(c);
            ovld_0 <= pop_hit;
            if (pop_hit) begin
                opri_0  <= pop_pri;
                odout_0 <= pop_dat;
            end
        end
    end

`ifdef PIFO_DROP_EN
    // Up to two evictions per cycle, reported one per cycle; the backlog waits in a small ring.
    rep_t       dq_q [4];
    logic [1:0] rp_q;
    logic [1:0] wp_q;
    logic [2:0] dn_q;

    rep_t       dq_d [4];
    logic [1:0] rp_d;
    logic [1:0] wp_d;
    logic [2:0] dn_d;
    rep_t       nl [2];
    int unsigned nn;
    int unsigned take;
    logic       dv_nxt;
    rep_t       dent_nxt;

    always_comb begin
        dq_d     = dq_q;
        rp_d     = rp_q;
        wp_d     = wp_q;
        dn_d     = dn_q;
        nl[0]    = '0;
        nl[1]    = '0;
        nn       = 0;
        take     = 0;
        dv_nxt   = 1'b0;
        dent_nxt = '0;

        if (ev1_vld) begin
            nl[0] = ev1;
            nn    = 1;
            if (ev2_vld) begin
                nl[1] = ev2;
                nn    = 2;
            end
        end else if (ev2_vld) begin
            nl[0] = ev2;
            nn    = 1;
        end

        if (dn_q != 3'd0) begin
            dv_nxt   = 1'b1;
            dent_nxt = dq_q[rp_q];
            rp_d     = rp_q + 2'd1;
            dn_d     = dn_q - 3'd1;
        end else if (nn != 0) begin
            dv_nxt   = 1'b1;
            dent_nxt = nl[0];
            take     = 1;
        end

        for (int unsigned k = 0; k < 2; k++) begin
            if (k >= take && k < nn && dn_d < 3'd4) begin
                dq_d[wp_d] = nl[k];
                wp_d       = wp_d + 2'd1;
                dn_d       = dn_d + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < 4; k++) dq_q[k] <= '0;
            rp_q         <= '0;
            wp_q         <= '0;
            dn_q         <= '0;
            odrop_vld_0  <= 1'b0;
            odrop_pri_0  <= '0;
            odrop_dout_0 <= '0;
        end else begin
            dq_q        <= dq_d;
            rp_q        <= rp_d;
            wp_q        <= wp_d;
            dn_q        <= dn_d;
            odrop_vld_0 <= dv_nxt;
            if (dv_nxt) begin
                odrop_pri_0  <= dent_nxt.pri;
                odrop_dout_0 <= dent_nxt.dat;
            end
        end
    end
`else
    assign odrop_vld_0  = 1'b0;
    assign odrop_pri_0  = '0;
    assign odrop_dout_0 = '0;
`endif

endmodule

// File: tb/tb_pifo_core.sv
// Scoreboard bench for pifo_core: directed pushes/pops queue expected results; monitors compare outputs.
module tb_pifo_core;

    localparam int NP = 8;
    localparam int BP = 1;
    localparam int BR = 8;
    localparam int BD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          pop_0;
    logic [BP-1:0] oprt_0;
    logic          ovld_0;
    logic [BR-1:0] opri_0;
    logic [BD-1:0] odout_0;
    logic          push_1;
    logic [BP-1:0] uprt_1;
    logic [BR-1:0] upri_1;
    logic [BD-1:0] udin_1;
    logic          push_1_drop;
    logic          push_2;
    logic [BP-1:0] uprt_2;
    logic [BR-1:0] upri_2;
    logic [BD-1:0] udin_2;
    logic          push_2_drop;
    logic          odrop_vld_0;
    logic [BR-1:0] odrop_pri_0;
    logic [BD-1:0] odrop_dout_0;

    int nvec = 0;
    int nerr = 0;

    logic [BR+BD-1:0] exp_pop  [$];
    logic [BR+BD-1:0] exp_drop [$];
    logic [BR+BD-1:0] mexp;
    logic [BR+BD-1:0] dexp;

    always #5 clk = ~clk;

    pifo_core #(
        .NUMPIFO(NP),
        .BITPORT(BP),
        .BITPRIO(BR),
        .BITDATA(BD),
        .PIFO_ID(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pop_0(pop_0),
        .oprt_0(oprt_0),
        .ovld_0(ovld_0),
        .opri_0(opri_0),
        .odout_0(odout_0),
        .push_1(push_1),
        .uprt_1(uprt_1),
        .upri_1(upri_1),
        .udin_1(udin_1),
        .push_1_drop(push_1_drop),
        .push_2(push_2),
        .uprt_2(uprt_2),
        .upri_2(upri_2),
        .udin_2(udin_2),
        .push_2_drop(push_2_drop),
        .odrop_vld_0(odrop_vld_0),
        .odrop_pri_0(odrop_pri_0),
        .odrop_dout_0(odrop_dout_0)
    );

    always @(negedge clk) begin
        if (ovld_0 === 1'b1) begin
            nvec++;
            if (exp_pop.size() == 0) begin
                nerr++;
                $display("FAIL pop_result got pri=%0d dat=%0d, required no output", opri_0, odout_0);
            end else begin
                mexp = exp_pop.pop_front();
                if ({opri_0, odout_0} !== mexp) begin
                    nerr++;
                    $display("FAIL pop_result got pri=%0d dat=%0d, required pri=%0d dat=%0d",
                             opri_0, odout_0, mexp[BR+BD-1:BD], mexp[BD-1:0]);
                end
            end
        end
        if (odrop_vld_0 === 1'b1) begin
            nvec++;
            if (exp_drop.size() == 0) begin
                nerr++;
                $display("FAIL drop_report got pri=%0d dat=%0d, required no eviction", odrop_pri_0, odrop_dout_0);
            end else begin
                dexp = exp_drop.pop_front();
                if ({odrop_pri_0, odrop_dout_0} !== dexp) begin
                    nerr++;
                    $display("FAIL drop_report got pri=%0d dat=%0d, required pri=%0d dat=%0d",
                             odrop_pri_0, odrop_dout_0, dexp[BR+BD-1:BD], dexp[BD-1:0]);
                end
            end
        end
    end

    task automatic idle();
        pop_0       = 1'b0;
        push_1      = 1'b0;
        push_2      = 1'b0;
        push_1_drop = 1'b0;
        push_2_drop = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_p1(input logic [BP-1:0] prt, input logic [BR-1:0] pri,
                          input logic [BD-1:0] dat, input logic drop);
        push_1 = 1'b1; uprt_1 = prt; upri_1 = pri; udin_1 = dat; push_1_drop = drop;
    endtask

    task automatic set_p2(input logic [BP-1:0] prt, input logic [BR-1:0] pri,
                          input logic [BD-1:0] dat, input logic drop);
        push_2 = 1'b1; uprt_2 = prt; upri_2 = pri; udin_2 = dat; push_2_drop = drop;
    endtask

    // exp_hit=0 means the pop must produce no output.
    task automatic set_pop(input logic [BP-1:0] prt, input logic exp_hit,
                           input logic [BR-1:0] epri, input logic [BD-1:0] edat);
        pop_0  = 1'b1;
        oprt_0 = prt;
        if (exp_hit) exp_pop.push_back({epri, edat});
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        nvec++;
        if (got !== req) begin
            nerr++;
            $display("FAIL %s got=%0d required=%0d", nm, got, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        oprt_0 = '0;
        uprt_1 = '0; upri_1 = '0; udin_1 = '0;
        uprt_2 = '0; upri_2 = '0; udin_2 = '0;
        rst = 1'b1;
        step();
        step();
        chk("rst_ovld", 32'(ovld_0), 0);
        chk("rst_opri", 32'(opri_0), 0);
        chk("rst_odout", 32'(odout_0), 0);
        chk("rst_odrop_vld", 32'(odrop_vld_0), 0);
        rst = 1'b0;

        // Basic ordering; push_2 at the same time as push_1
        set_p1(0, 5, 1, 0); step();
        set_p1(0, 2, 2, 0); set_p2(0, 9, 3, 0); step();
        set_pop(0, 1, 2, 2); step();
        set_pop(0, 1, 5, 1); step();
        set_pop(0, 1, 9, 3); step();

        // Tie ordering, sequential and same-cycle; drop flag on an idle port is inert
        set_p1(0, 7, 10, 0); step();
        set_p1(0, 7, 11, 0); push_2_drop = 1'b1; step();
        set_p1(0, 7, 20, 0); set_p2(0, 7, 21, 0); step();
        set_pop(0, 1, 7, 10); step();
        set_pop(0, 1, 7, 11); step();
        set_pop(0, 1, 7, 20); step();
        set_pop(0, 1, 7, 21); step();

        // Port filtering
        set_p1(1, 1, 40, 0); set_p2(0, 3, 41, 0); step();
        set_pop(0, 1, 3, 41); step();
        set_pop(1, 1, 1, 40); step();
        set_p1(0, 2, 42, 0); step();
        set_pop(1, 0, 0, 0); step();
        set_pop(0, 1, 2, 42); step();

        // Empty pops, push and pop together on empty
        set_pop(0, 0, 0, 0); step();
        set_p1(0, 4, 50, 0); set_pop(0, 0, 0, 0); step();
        set_pop(0, 1, 4, 50); step();
        set_pop(0, 0, 0, 0); step();

        // Two pushes and a pop in one cycle; pop takes the pre-existing entry
        set_p1(0, 6, 60, 0); step();
        set_p1(0, 1, 61, 0); set_p2(0, 2, 62, 0); set_pop(0, 1, 6, 60); step();
        set_pop(0, 1, 1, 61); step();
        set_pop(0, 1, 2, 62); step();

        // Evict-on-push
        set_p1(0, 3, 70, 0); set_p2(0, 8, 71, 0); step();
`ifdef PIFO_DROP_EN
        set_p1(0, 6, 72, 1); exp_drop.push_back({8'd8, 8'd71}); step();
        set_pop(0, 1, 3, 70); step();
        set_pop(0, 1, 6, 72); step();
        set_p1(0, 5, 80, 0); set_p2(0, 9, 81, 0); step();
        set_p1(0, 7, 82, 0); step();
        set_p1(0, 4, 83, 1); set_p2(0, 10, 84, 1);
        exp_drop.push_back({8'd9, 8'd81});
        exp_drop.push_back({8'd10, 8'd84});
        step();
        set_pop(0, 1, 4, 83); step();
        set_pop(0, 1, 5, 80); step();
        set_pop(0, 1, 7, 82); step();
`else
        set_p1(0, 6, 72, 1); step();
        set_pop(0, 1, 3, 70); step();
        set_pop(0, 1, 6, 72); step();
        set_pop(0, 1, 8, 71); step();
`endif

        // Push to a full queue without the drop flag
        for (int i = 0; i < NP; i++) begin
            set_p1(0, 8'(i), 8'(100 + i), 0);
            step();
        end
        set_p1(0, 0, 99, 0);
`ifdef PIFO_DROP_EN
        exp_drop.push_back({8'(NP - 1), 8'(100 + NP - 1)});
        step();
        set_pop(0, 1, 0, 100); step();
        set_pop(0, 1, 0, 99); step();
        for (int i = 1; i < NP - 1; i++) begin
            set_pop(0, 1, 8'(i), 8'(100 + i));
            step();
        end
`else
        step();
        for (int i = 0; i < NP; i++) begin
            set_pop(0, 1, 8'(i), 8'(100 + i));
            step();
        end
`endif
        set_pop(0, 0, 0, 0); step();

        // Reset mid-operation; pushes presented during reset are ignored
        set_p1(0, 3, 90, 0); set_p2(0, 1, 91, 0); step();
        set_p1(0, 2, 92, 0); step();
        rst = 1'b1;
        set_p1(0, 1, 93, 0);
        step();
        rst = 1'b0;
        set_pop(0, 0, 0, 0); step();
        chk("post_rst_ovld", 32'(ovld_0), 0);
        chk("post_rst_opri", 32'(opri_0), 0);
        chk("post_rst_odout", 32'(odout_0), 0);
        chk("post_rst_odrop_vld", 32'(odrop_vld_0), 0);
        set_pop(1, 0, 0, 0); step();

        repeat (4) step();
        chk("pop_leftover", 32'(exp_pop.size()), 0);
        chk("drop_leftover", 32'(exp_drop.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
